// File: rtl/sub_8bit_seq_pkg.sv
// sub_seq_pkg: shared types and constants for the digit-serial subtractor.
//   state_e      - controller states (IDLE, DIGIT, TOP, DONE)
//   DIGIT_W_DEF  - default number of bits subtracted per DIGIT cycle
//   digit_count  - number of DIGIT cycles for a given operand width
package sub_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    TOP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DIGIT_W_DEF = 4;

  function automatic int digit_count(input int width, input int digit_w);
    return width / digit_w;
  endfunction

endpackage

// File: rtl/sub_8bit_seq_if.sv
// sub_8bit_seq_if: operand/result handshake bundle for sub_8bit_seq.
//   in_valid/in_ready   - operand handshake (sum, a)
//   out_valid/out_ready - result handshake (b, underflow, overflow)
//   mismatch            - re-add self-check flag, present only when
//                         SUB_8BIT_SEQ_SELFCHECK_EN is defined
// master = producer/consumer side, slave = the subtractor.
interface sub_8bit_seq_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] a;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] b;
  logic             underflow;
  logic             overflow;

`ifdef SUB_8BIT_SEQ_SELFCHECK_EN
  logic             mismatch;

  modport master (
    output in_valid, sum, a, out_ready,
    input  in_ready, out_valid, b, underflow, overflow, mismatch
  );

  modport slave (
    input  in_valid, sum, a, out_ready,
    output in_ready, out_valid, b, underflow, overflow, mismatch
  );
`else
  modport master (
    output in_valid, sum, a, out_ready,
    input  in_ready, out_valid, b, underflow, overflow
  );

  modport slave (
    input  in_valid, sum, a, out_ready,
    output in_ready, out_valid, b, underflow, overflow
  );
`endif

endinterface

// File: rtl/sub_8bit_seq_digit.sv
// sub_digit: DIGIT_W-bit subtractor d = x - y - bin with borrow out.
//   x_i, y_i  - minuend / subtrahend digit
//   bin_i     - borrow in
//   d_o       - difference digit
//   bout_o    - borrow out
// Borrows are formed from generate (~x & y) and propagate (~(x ^ y)) terms.
module sub_digit #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] x_i,
  input  logic [DIGIT_W-1:0] y_i,
  input  logic               bin_i,
  output logic [DIGIT_W-1:0] d_o,
  output logic               bout_o
);

  logic [DIGIT_W-1:0] g;
  logic [DIGIT_W-1:0] p;
  logic [DIGIT_W:0]   c;

  assign g = ~x_i & y_i;
  assign p = ~(x_i ^ y_i);

  always_comb begin
    c    = '0;
    c[0] = bin_i;
    for (int i = 0; i < DIGIT_W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign d_o    = x_i ^ y_i ^ c[DIGIT_W-1:0];
  assign bout_o = c[DIGIT_W];

endmodule

// File: rtl/sub_8bit_seq.sv
// sub_8bit_seq: digit-serial inverse of the 8-bit adder, b = sum - a.
// One DIGIT_W-bit subtract per DIGIT cycle, then a 1-bit TOP step that
// resolves the sum MSB against the running borrow and sets the flags.
//   clk, rst  - clock, synchronous active-high reset
//   bus_if    - slave side of sub_8bit_seq_if (operands in, result out)
// Optional: SUB_8BIT_SEQ_SELFCHECK_EN adds bus_if.mismatch, set when
// a + {d8, b} does not reproduce the latched sum.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// DIGIT | subtracting digit idx, one digit per cycle
// TOP   | resolving sum MSB, computing underflow/overflow
// DONE  | result presented, out_valid=1
module sub_8bit_seq
  import sub_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = DIGIT_W_DEF
) (
  input logic           clk,
  input logic           rst,
  sub_8bit_seq_if.slave bus_if
);

  localparam int NDIG  = digit_count(WIDTH, DIGIT_W);
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((WIDTH % DIGIT_W) != 0) begin : g_bad_digit_w
    $error("sub_8bit_seq: WIDTH must be a multiple of DIGIT_W");
  end

  state_e           state_q, state_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             uf_q, uf_d;
  logic             of_q, of_d;

  logic             in_ready;
  logic             hs;
  int               base;
  logic [DIGIT_W-1:0] x_dig, y_dig, d_dig;
  logic             bout_dig;
  logic             d8;
  logic             top_borrow;

  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & bus_if.out_ready);
  assign hs       = bus_if.in_valid & in_ready;

  // Single subtractor shared by all digits, selected by the digit index.
  assign base  = int'(idx_q) * DIGIT_W;
  assign x_dig = sum_q[base +: DIGIT_W];
  assign y_dig = a_q[base +: DIGIT_W];

  sub_digit #(.DIGIT_W(DIGIT_W)) u_digit (
    .x_i   (x_dig),
    .y_i   (y_dig),
    .bin_i (borrow_q),
    .d_o   (d_dig),
    .bout_o(bout_dig)
  );

  // 1-bit subtract of the sum MSB minus the borrow out of the low digits.
  assign d8         = sum_q[WIDTH] ^ borrow_q;
  assign top_borrow = ~sum_q[WIDTH] & borrow_q;

`ifdef SUB_8BIT_SEQ_SELFCHECK_EN
  logic             mm_q, mm_d;
  logic [WIDTH:0]   resum;

  assign resum = {1'b0, a_q} + {d8, b_q};
`endif

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    uf_d     = uf_q;
    of_d     = of_q;
`ifdef SUB_8BIT_SEQ_SELFCHECK_EN
    mm_d     = mm_q;
`endif

    case (state_q)
      IDLE: begin
        if (hs) state_d = DIGIT;
      end
      DIGIT: begin
        b_d[base +: DIGIT_W] = d_dig;
        borrow_d             = bout_dig;
        if (idx_q == IDX_W'(NDIG - 1)) begin
          idx_d   = '0;
          state_d = TOP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      TOP: begin
        uf_d    = top_borrow;
        of_d    = ~top_borrow & d8;
`ifdef SUB_8BIT_SEQ_SELFCHECK_EN
        mm_d    = (resum != sum_q);
`endif
        state_d = DONE;
      end
      DONE: begin
        if (bus_if.out_ready) state_d = hs ? DIGIT : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // hs can only be true in IDLE or DONE, so the load never collides
    // with the DIGIT/TOP updates above.
    if (hs) begin
      sum_d    = bus_if.sum;
      a_d      = bus_if.a;
      borrow_d = 1'b0;
      idx_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sum_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      uf_q     <= 1'b0;
      of_q     <= 1'b0;
`ifdef SUB_8BIT_SEQ_SELFCHECK_EN
      mm_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
      uf_q     <= uf_d;
      of_q     <= of_d;
`ifdef SUB_8BIT_SEQ_SELFCHECK_EN
      mm_q     <= mm_d;
`endif
    end
  end

  assign bus_if.in_ready  = in_ready;
  assign bus_if.out_valid = (state_q == DONE);
  assign bus_if.b         = b_q;
  assign bus_if.underflow = uf_q;
  assign bus_if.overflow  = of_q;
`ifdef SUB_8BIT_SEQ_SELFCHECK_EN
  assign bus_if.mismatch  = mm_q;
`endif

endmodule

// File: doc/sub_8bit_seq.md
Name: sub_8bit_seq

Overview:
Inverse of the cla_8bit adder: recovers operand b from a 9-bit sum and 8-bit operand a, computing b = sum - a.
- Digit-serial: one DIGIT_W-bit lookahead subtract per cycle, then a final top-bit step.
- valid/ready handshake on input and output.
- Sits beside cla_8bit as an inverse/self-check unit in the arithmetic datapath.

Parameters:
WIDTH, 8, operand a / result b width; sum is WIDTH+1 bits.
DIGIT_W, 4, bits subtracted per cycle; WIDTH % DIGIT_W must be 0 (elaboration-time check).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operands present
in_ready  output  1  block accepts operands this cycle
sum  input  WIDTH+1  minuend
a  input  WIDTH  subtrahend
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
b  output  WIDTH  (sum - a) mod 2^WIDTH
underflow  output  1  sum < a
overflow  output  1  sum - a > 2^WIDTH-1

Behaviour:
- Reset (rst high at clk edge): state IDLE, out_valid=0, b=0, underflow=0, overflow=0, internal borrow=0, digit index=0. in_ready is combinational and equals 1 in IDLE.
- Reset mid-operation: operation is abandoned with no output; the next cycle is IDLE.
- FSM states:
  - IDLE -> DIGIT on an input handshake (in_valid & in_ready). Operands are latched and borrow is cleared.
  - DIGIT: each cycle subtracts latched sum digit[i] - a digit[i] - borrow and writes b digit[i] and borrow. Stays for WIDTH/DIGIT_W cycles, then -> TOP.
  - TOP: computes d8 = sum[WIDTH] - borrow (1-bit subtract), giving borrow_out and d8. Sets underflow=borrow_out and overflow=(~borrow_out & d8). -> DONE.
  - DONE: out_valid=1. On out_ready -> IDLE, unless a new input handshake occurs in the same cycle, in which case -> DIGIT.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Latency: with default parameters, out_valid rises 3 cycles after the input handshake edge. Throughput is one result per 4 cycles back-to-back.
- Output stability: b, underflow and overflow are stable while out_valid=1 and out_ready=0, for any stall length.
- Flag rules:
  - underflow and overflow are mutually exclusive.
  - On underflow, b holds the two's-complement wrap.
  - On overflow, b holds the low WIDTH bits.
- Inputs are ignored outside the handshake; sum and a may change freely after acceptance.
- in_valid held high in DIGIT or TOP: no acceptance and no effect.

Optional Feature:
Macro SUB_8BIT_SEQ_SELFCHECK_EN.
- Defined:
  - Adds output port mismatch (1 bit).
  - In TOP, the block re-adds latched a + {d8, b} (WIDTH+1 bits) and compares the result with latched sum.
  - mismatch is registered and valid alongside out_valid; reset value is 0.
  - mismatch must be 0 whenever underflow=0.
- Not defined: the port, adder and comparator are absent. Behaviour is otherwise identical.

Decomposition:
Package sub_seq_pkg holds:
- state enum type (IDLE, DIGIT, TOP, DONE)
- DIGIT_W default constant
- localparam function computing the digit count

One sub-module, sub_digit:
- DIGIT_W-bit subtractor with borrow-in and borrow-out.
- Internal generate/propagate lookahead (g = ~x & y, p = ~(x ^ y)).
- Instantiated once and reused each DIGIT cycle through the digit-index mux.

Test Plan:
1. sum=300, a=100, out_ready=1 -> out_valid 3 cycles after accept; b=200, underflow=0, overflow=0.
2. sum=50, a=100 -> b=206, underflow=1, overflow=0.
3. sum=511, a=0 -> b=255, overflow=1, underflow=0. Also sum=256, a=0 -> b=0, overflow=1.
4. Backpressure: sum=7, a=3 with out_ready=0 for 5 cycles -> out_valid held, b=4 stable, in_ready=0. out_ready=1 with in_valid=1 (sum=9, a=9) -> same-cycle accept; next result b=0, flags 0.
5. Reset mid-op: rst asserted in the second DIGIT cycle -> next cycle IDLE, out_valid=0, b=0, no spurious result. Next op sum=10, a=4 -> b=6.
6. Exhaustive sweep: all sum 0..511 x a 0..255 back-to-back vs reference model. Check b, flags and throughput of 1 per 4 cycles. With SUB_8BIT_SEQ_SELFCHECK_EN, mismatch=0 for every non-underflow case.
